// File: rtl/fp_alu_arbiter.sv
// Two-requester round-robin front end that sequences one shared combinational FP ALU.
// Latency: accept + EXEC length (1/2/4 cycles) + 1 to rsp_valid; illegal ops respond at accept + 1.
// Backpressure: one transaction in flight; req_ready stays 00 until the response handshakes.
module fp_alu_arbiter #(
    parameter int N = 32,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req_op,
    input  logic [2*N-1:0]   req_a,
    input  logic [2*N-1:0]   req_b,
    output logic [2:0]       alu_sel,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    input  logic [N-1:0]     alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             busy
);

    typedef struct packed {
        logic           sign;
        logic [M-1:0]   exp;
        logic [N-M-2:0] frac;
    } fp_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t     state_q, state_d;
    logic       last_q;
    logic [1:0] cnt_q;
    logic [2:0] op_q;
    fp_t        a_q, b_q, data_q;
    logic       id_q, err_q;

    logic       any_vld, gnt_idx, fire, op_legal;
    logic [2:0] gnt_op;
    logic [1:0] gnt_cnt;

    // On a tie the requester not served last wins; reset leaves last_q=1 so requester 0 wins first.
    assign any_vld  = |req_valid;
    assign gnt_idx  = (&req_valid) ? ~last_q : req_valid[1];
    assign gnt_op   = gnt_idx ? req_op[5:3] : req_op[2:0];
    assign op_legal = (gnt_op != 3'd0) && (gnt_op <= 3'd5);
    assign fire     = (state_q == S_IDLE) && any_vld;

    always_comb begin
        case (gnt_op)
            3'd3:    gnt_cnt = 2'd1;
            3'd4:    gnt_cnt = 2'd3;
            default: gnt_cnt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_vld) state_d = op_legal ? S_EXEC : S_RESP;
            S_EXEC:  if (cnt_q == 2'd0) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        alu_sel   = 3'd0;
        alu_a     = '0;
        alu_b     = '0;
        if (state_q == S_IDLE && any_vld) req_ready[gnt_idx] = 1'b1;
        if (state_q == S_EXEC) begin
            alu_sel = op_q;
            alu_a   = a_q;
            alu_b   = b_q;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
            cnt_q  <= 2'd0;
            op_q   <= 3'd0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            id_q   <= 1'b0;
            err_q  <= 1'b0;
        end else if (fire) begin
            last_q <= gnt_idx;
            op_q   <= gnt_op;
            a_q    <= gnt_idx ? req_a[2*N-1:N] : req_a[N-1:0];
            b_q    <= gnt_idx ? req_b[2*N-1:N] : req_b[N-1:0];
            id_q   <= gnt_idx;
            cnt_q  <= gnt_cnt;
            if (!op_legal) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end else if (state_q == S_EXEC) begin
            if (cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end else begin
                data_q <= alu_result;
                err_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed bench for fp_alu_arbiter with a behavioural ALU stand-in (known FP vectors, integer ops otherwise).
module tb_fp_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id, rsp_err, busy;

    int compared = 0;
    int mismatched = 0;

    fp_alu_arbiter #(.N(32), .M(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] alu_model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel == 3'd1 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (sel == 3'd3 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40000000;
        if (sel == 3'd3 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (sel == 3'd4 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        case (sel)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a * b;
            3'd4:    return (b == 32'd0) ? 32'd0 : a / b;
            3'd5:    return a ^ b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign alu_result = alu_model(alu_sel, alu_a, alu_b);

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin mismatched++;
            $display("FAIL reset_rsp_fields got data=%h id=%b err=%b want 0/0/0", rsp_data, rsp_id, rsp_err); end
        compared++; if (alu_sel !== 3'd0 || req_ready !== 2'b00) begin mismatched++;
            $display("FAIL reset_alu_ready got sel=%0d ready=%b want 0/00", alu_sel, req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 2'b01; req_op = {3'd0, 3'd1};
        req_a = {32'h0, 32'h3F800000}; req_b = {32'h0, 32'h40000000};
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL add_grant got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        compared++; if (alu_sel !== 3'd1 || alu_a !== 32'h3F800000 || alu_b !== 32'h40000000) begin mismatched++;
            $display("FAIL add_exec got sel=%0d a=%h b=%h want 1/3f800000/40000000", alu_sel, alu_a, alu_b); end
        compared++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin mismatched++;
            $display("FAIL add_exec_ctl got busy=%b vld=%b rdy=%b want 1/0/00", busy, rsp_valid, req_ready); end
        @(negedge clk);
        #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin mismatched++;
            $display("FAIL add_resp got vld=%b data=%h id=%b err=%b want 1/40400000/0/0", rsp_valid, rsp_data, rsp_id, rsp_err); end
        compared++; if (alu_sel !== 3'd0 || alu_a !== 32'd0) begin mismatched++;
            $display("FAIL add_alu_idle got sel=%0d a=%h want 0/0", alu_sel, alu_a); end
        @(negedge clk);
        #1;
        compared++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin mismatched++;
            $display("FAIL add_done got vld=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  ids [2];
        logic [31:0] dats [2];
        int nresp = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1; req_valid = 2'b11; req_op = {3'd3, 3'd3};
        req_a = {32'h40000000, 32'h3F800000}; req_b = {32'h40400000, 32'h40000000};
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL rr_first_grant got %b want 01", req_ready); end
        for (int i = 0; i < 30 && nresp < 2; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                ids[nresp]  = {1'b0, rsp_id};
                dats[nresp] = rsp_data;
                nresp++;
                if (nresp == 2) req_valid = 2'b00;
            end
        end
        compared++; if (nresp != 2) begin mismatched++; $display("FAIL rr_timeout got %0d responses want 2", nresp); end
        else begin
            compared++; if (ids[0] !== 2'd0 || ids[1] !== 2'd1) begin mismatched++;
                $display("FAIL rr_order got ids %0d,%0d want 0,1", ids[0], ids[1]); end
            compared++; if (dats[0] !== 32'h40000000 || dats[1] !== 32'h40C00000) begin mismatched++;
                $display("FAIL rr_data got %h,%h want 40000000,40c00000", dats[0], dats[1]); end
        end
        @(negedge clk);
    endtask

    task automatic test_div();
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 2'b10; req_op = {3'd4, 3'd0};
        req_a = {32'h40C00000, 32'h0}; req_b = {32'h40000000, 32'h0};
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL div_grant got %b want 10", req_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            compared++; if (alu_sel !== 3'd4 || alu_a !== 32'h40C00000 || alu_b !== 32'h40000000 || rsp_valid !== 1'b0) begin mismatched++;
                $display("FAIL div_exec_c%0d got sel=%0d a=%h b=%h vld=%b want 4/40c00000/40000000/0", c, alu_sel, alu_a, alu_b, rsp_valid); end
        end
        @(negedge clk);
        #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin mismatched++;
            $display("FAIL div_resp got vld=%b data=%h id=%b err=%b want 1/40400000/1/0", rsp_valid, rsp_data, rsp_id, rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 2'b01; req_op = {3'd0, 3'd7};
        req_a = {32'h0, 32'h12345678}; req_b = {32'h0, 32'h9ABCDEF0};
        #1;
        compared++; if (alu_sel !== 3'd0) begin mismatched++; $display("FAIL ill_sel_idle got %0d want 0", alu_sel); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_err !== 1'b1 || rsp_id !== 1'b0) begin mismatched++;
            $display("FAIL ill_resp got vld=%b data=%h err=%b id=%b want 1/0/1/0", rsp_valid, rsp_data, rsp_err, rsp_id); end
        compared++; if (alu_sel !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin mismatched++;
            $display("FAIL ill_alu got sel=%0d a=%h b=%h want 0/0/0", alu_sel, alu_a, alu_b); end
        @(negedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ill_done got busy=%b want 0", busy); end
    endtask

    task automatic test_cmp();
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 2'b01; req_op = {3'd0, 3'd5};
        req_a = {32'h0, 32'h00000001}; req_b = {32'h0, 32'h00000002};
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000003 || rsp_err !== 1'b0) begin mismatched++;
            $display("FAIL cmp_resp got vld=%b data=%h err=%b want 1/00000003/0", rsp_valid, rsp_data, rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 2'b01; req_op = {3'd2, 3'd2};
        req_a = {32'h00000009, 32'h00000005}; req_b = {32'h00000001, 32'h00000003};
        @(negedge clk);
        req_valid = 2'b11;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            compared++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000002 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin mismatched++;
                $display("FAIL bp_hold_c%0d got vld=%b data=%h id=%b err=%b want 1/00000002/0/0", c, rsp_valid, rsp_data, rsp_id, rsp_err); end
            compared++; if (req_ready !== 2'b00 || busy !== 1'b1) begin mismatched++;
                $display("FAIL bp_ctl_c%0d got rdy=%b busy=%b want 00/1", c, req_ready, busy); end
        end
        rsp_ready = 1'b1;
        #1;
        compared++; if (req_ready !== 2'b00) begin mismatched++; $display("FAIL bp_handshake_grant got %b want 00", req_ready); end
        @(negedge clk);
        #1;
        compared++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b10) begin mismatched++;
            $display("FAIL bp_idle got vld=%b busy=%b rdy=%b want 0/0/10", rsp_valid, busy, req_ready); end
        req_valid = 2'b00;
        #1;
        compared++; if (req_ready !== 2'b00) begin mismatched++; $display("FAIL bp_drop_valid got %b want 00", req_ready); end
        @(negedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_no_transfer got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_exec();
        logic seen = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 2'b10; req_op = {3'd4, 3'd0};
        req_a = {32'h40C00000, 32'h0}; req_b = {32'h40000000, 32'h0};
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin mismatched++;
            $display("FAIL rst_mid_rsp got vld=%b busy=%b data=%h id=%b err=%b want 0/0/0/0/0", rsp_valid, busy, rsp_data, rsp_id, rsp_err); end
        compared++; if (alu_sel !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || req_ready !== 2'b00) begin mismatched++;
            $display("FAIL rst_mid_alu got sel=%0d a=%h b=%h rdy=%b want 0/0/0/00", alu_sel, alu_a, alu_b, req_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL rst_mid_dropped got response=%b want 0", seen); end
        req_valid = 2'b11; req_op = {3'd1, 3'd1};
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL rst_mid_rr_ptr got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_div();
        test_illegal();
        test_cmp();
        test_backpressure();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
